// File: rtl/dma_pkg.sv
// Shared DMA definitions: transfer size codes and bus width.
package dma_pkg;

   localparam int unsigned BusWidth = 32;

   typedef enum logic [1:0] {
      SizeByte = 2'd0,
      SizeHalf = 2'd1,
      SizeWord = 2'd2
   } size_e;

   // Size code to byte count; the reserved code maps to 0.
   function automatic logic [2:0] size_bytes(input logic [1:0] code);
      logic [2:0] n;
      case (code)
         SizeByte: n = 3'd1;
         SizeHalf: n = 3'd2;
         SizeWord: n = 3'd4;
         default:  n = 3'd0;
      endcase
      return n;
   endfunction

   function automatic logic size_legal(input logic [1:0] code);
      return code != 2'd3;
   endfunction

endpackage

// File: rtl/dma_fifo.sv
// Byte-granular circular FIFO with byte/halfword/word put and show-ahead pull.
module dma_fifo
   import dma_pkg::*;
#(
   parameter int unsigned fifo_size_exp = 4
) (
   input  logic                   i_clk,
   input  logic                   i_nreset,
   input  logic                   i_put,
   input  logic [1:0]             i_numb_bytes_put,
   input  logic [BusWidth-1:0]    i_wdata,
   input  logic                   i_pull,
   input  logic [1:0]             i_numb_bytes_pull,
   output logic [BusWidth-1:0]    o_rdata,
   output logic [fifo_size_exp:0] o_left_put,
   output logic [fifo_size_exp:0] o_left_pull,
   input  logic                   i_flush,
   output logic                   o_empty,
   output logic                   o_full,
   output logic                   o_overflow,
   output logic                   o_underflow
);

   localparam int unsigned Depth = 1 << fifo_size_exp;
   localparam int unsigned AW    = fifo_size_exp;
   localparam int unsigned CW    = fifo_size_exp + 1;

   logic [7:0]    mem_q [Depth];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q, free;
   logic          overflow_q, underflow_q;

   logic [2:0]    n_put, n_pull;
   logic          put_acc, pull_acc;
   logic [CW-1:0] put_add, pull_sub;

   // Acceptance decisions, each against the pre-edge count only.
   always_comb begin
      n_put    = size_bytes(i_numb_bytes_put);
      n_pull   = size_bytes(i_numb_bytes_pull);
      free     = CW'(Depth) - count_q;
      put_acc  = i_put && size_legal(i_numb_bytes_put) && (free >= CW'(n_put));
      pull_acc = i_pull && size_legal(i_numb_bytes_pull) && (count_q >= CW'(n_pull));
      put_add  = put_acc ? CW'(n_put) : '0;
      pull_sub = pull_acc ? CW'(n_pull) : '0;
   end

   // Pointers, count and error pulses; flush wins over any request.
   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (i_flush) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (put_acc)  wptr_q <= wptr_q + AW'(n_put);
         if (pull_acc) rptr_q <= rptr_q + AW'(n_pull);
         count_q     <= count_q + put_add - pull_sub;
         overflow_q  <= i_put && !put_acc;
         underflow_q <= i_pull && !pull_acc;
      end
   end

   // Byte array write; lane k lands at wptr+k with natural wrap. Not reset.
   always_ff @(posedge i_clk) begin
      if (put_acc && !i_flush) begin
         for (int k = 0; k < 4; k++) begin
            if (3'(k) < n_put) mem_q[wptr_q + AW'(k)] <= i_wdata[8*k +: 8];
         end
      end
   end

   // Show-ahead read: lanes beyond the requested size are zero.
   always_comb begin
      o_rdata = '0;
      for (int k = 0; k < 4; k++) begin
         if (3'(k) < n_pull) o_rdata[8*k +: 8] = mem_q[rptr_q + AW'(k)];
      end
   end

   assign o_left_pull = count_q;
   assign o_left_put  = CW'(Depth) - count_q;
   assign o_empty     = (count_q == '0);
   assign o_full      = (count_q == CW'(Depth));
   assign o_overflow  = overflow_q;
   assign o_underflow = underflow_q;

endmodule

// File: tb/tb_dma_fifo.sv
// Directed self-checking bench for dma_fifo at depth 16.
module tb_dma_fifo;

   logic        clk = 1'b0;
   logic        nreset;
   logic        put, pull, flush;
   logic [1:0]  size_put, size_pull;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [4:0]  left_put, left_pull;
   logic        empty, full, ovf, unf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dma_fifo #(.fifo_size_exp(4)) dut (
      .i_clk             (clk),
      .i_nreset          (nreset),
      .i_put             (put),
      .i_numb_bytes_put  (size_put),
      .i_wdata           (wdata),
      .i_pull            (pull),
      .i_numb_bytes_pull (size_pull),
      .o_rdata           (rdata),
      .o_left_put        (left_put),
      .o_left_pull       (left_pull),
      .i_flush           (flush),
      .o_empty           (empty),
      .o_full            (full),
      .o_overflow        (ovf),
      .o_underflow       (unf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic put_op(input logic [1:0] sz, input logic [31:0] d);
      put = 1'b1; size_put = sz; wdata = d;
      cycle();
      put = 1'b0;
   endtask

   // Check show-ahead data before the edge, then pull.
   task automatic pull_op(input string tag, input logic [1:0] sz, input logic [31:0] exp);
      size_pull = sz; pull = 1'b1;
      #1 check(tag, rdata, exp);
      cycle();
      pull = 1'b0;
   endtask

   task automatic status(input string tag, input int cnt, input logic o, input logic u);
      check({tag, "_pull"}, 32'(left_pull), 32'(cnt));
      check({tag, "_put"}, 32'(left_put), 32'(16 - cnt));
      check({tag, "_empty"}, 32'(empty), 32'(cnt == 0));
      check({tag, "_full"}, 32'(full), 32'(cnt == 16));
      check({tag, "_ovf"}, 32'(ovf), 32'(o));
      check({tag, "_unf"}, 32'(unf), 32'(u));
   endtask

   initial begin
      logic [31:0] w [4];
      nreset = 1'b0; put = 1'b0; pull = 1'b0; flush = 1'b0;
      size_put = 2'd0; size_pull = 2'd0; wdata = '0;

      // Reset state
      #3 status("reset", 0, 1'b0, 1'b0);
      #4 nreset = 1'b1;
      cycle();

      // Single word put, then byte and halfword pulls
      put_op(2'd2, 32'h4433_2211);
      status("put1", 4, 1'b0, 1'b0);
      pull_op("rd_byte", 2'd0, 32'h0000_0011);
      check("cnt_after_byte", 32'(left_pull), 32'd3);
      pull_op("rd_half", 2'd1, 32'h0000_3322);
      pull_op("rd_byte2", 2'd0, 32'h0000_0044);
      status("drained", 0, 1'b0, 1'b0);

      // Fill to full, then overflow (pointers start at 4, so this wraps)
      w[0] = 32'h0302_0100; w[1] = 32'h0706_0504;
      w[2] = 32'h0B0A_0908; w[3] = 32'h0F0E_0D0C;
      for (int i = 0; i < 4; i++) put_op(2'd2, w[i]);
      status("full", 16, 1'b0, 1'b0);
      put_op(2'd2, 32'hDEAD_BEEF);
      status("ovf_pulse", 16, 1'b1, 1'b0);
      cycle();
      status("ovf_clear", 16, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) pull_op($sformatf("full_rd%0d", i), 2'd2, w[i]);
      status("full_drained", 0, 1'b0, 1'b0);

      // Wrap: offset by 3 bytes, then words walk across index 15/0
      put_op(2'd0, 32'h0000_0001);
      put_op(2'd0, 32'h0000_0002);
      put_op(2'd0, 32'h0000_0003);
      pull_op("wrap_half", 2'd1, 32'h0000_0201);
      pull_op("wrap_byte", 2'd0, 32'h0000_0003);
      w[0] = 32'hDDCC_BBAA; w[1] = 32'h1122_3344;
      w[2] = 32'hA5A5_5A5A; w[3] = 32'h0BAD_CAFE;
      for (int i = 0; i < 4; i++) begin
         put_op(2'd2, w[i]);
         pull_op($sformatf("wrap_rd%0d", i), 2'd2, w[i]);
      end
      status("wrap_done", 0, 1'b0, 1'b0);

      // Simultaneous put word / pull word with only 2 stored
      put_op(2'd1, 32'h0000_BEEF);
      put = 1'b1; size_put = 2'd2; wdata = 32'h1234_5678;
      pull = 1'b1; size_pull = 2'd2;
      cycle();
      put = 1'b0; pull = 1'b0;
      status("simul", 6, 1'b0, 1'b1);
      #1 check("simul_rdata", rdata, 32'h5678_BEEF);
      cycle();
      check("simul_unf_clear", 32'(unf), 32'd0);

      // Flush beats a concurrent put, with no error pulses
      put_op(2'd1, 32'h0000_9999);
      check("pre_flush", 32'(left_pull), 32'd8);
      flush = 1'b1; put = 1'b1; size_put = 2'd2; wdata = 32'hFFFF_FFFF;
      cycle();
      flush = 1'b0; put = 1'b0;
      status("flush", 0, 1'b0, 1'b0);

      // Reserved size code on each side
      put_op(2'd3, 32'h1111_1111);
      status("bad_put", 0, 1'b1, 1'b0);
      put_op(2'd1, 32'h0000_2222);
      size_pull = 2'd3; pull = 1'b1;
      cycle();
      pull = 1'b0;
      status("bad_pull", 2, 1'b0, 1'b1);
      pull_op("after_bad", 2'd1, 32'h0000_2222);

      // Asynchronous reset mid-stream at count 10
      put_op(2'd2, 32'h0101_0101);
      put_op(2'd2, 32'h0202_0202);
      put_op(2'd1, 32'h0000_0303);
      check("pre_reset", 32'(left_pull), 32'd10);
      #2 nreset = 1'b0;
      #1 status("async_reset", 0, 1'b0, 1'b0);
      #2 nreset = 1'b1;
      cycle();
      put_op(2'd2, 32'hCAFE_F00D);
      status("post_reset", 4, 1'b0, 1'b0);
      size_pull = 2'd2;
      #1 check("post_reset_rd", rdata, 32'hCAFE_F00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
